if_fetch_stage: RTL

- Instruction-fetch stage of the external-RAM pipeline.
- Owns the PC register and the request/acknowledge handshake to external instruction memory.
- Presents pc_if, pc8_if and instr_if to the IF/ID pipeline register and obeys the same stage enable.
- Inserts NOP bubbles while memory is slow. Applies branch/jump redirects after the delay slot.

---
 rtl/if_fetch_stage.sv | 103 ++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the req/ack handshake to external instruction RAM.
// It inserts NOP bubbles while RAM is slow and applies branch/jump redirects after the delay slot.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] pc8_if,
  output logic [31:0] instr_if,
  output logic        if_valid,
  output logic        dbg_state
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic        r_pend;
  logic [31:0] r_pend_target;

  logic        w_deliver;
  logic [31:0] w_target_aligned;
  logic [31:0] w_next_pc;

  // Handshake: imem_req stays high with a stable imem_addr until a one-cycle
  // imem_ack returns the word; delivery to IF/ID happens when if_valid && ena.
  assign imem_req  = !rst && (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign pc_if     = r_pc;
  assign pc8_if    = r_pc + 32'd8;
  assign if_valid  = !rst && ((r_state == ST_HOLD) || imem_ack);
  assign dbg_state = (r_state == ST_HOLD);

  always_comb begin
    instr_if = NOP_INSTR;
    if (if_valid) begin
      instr_if = (r_state == ST_HOLD) ? r_hold_buf : imem_rdata;
    end
  end

  assign w_deliver        = if_valid && ena;
  assign w_target_aligned = redirect_target & 32'hFFFF_FFFC;

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (redirect) begin
      w_next_pc = w_target_aligned;
    end else if (r_pend) begin
      w_next_pc = r_pend_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_hold_buf    <= 32'd0;
      r_pend        <= 1'b0;
      r_pend_target <= 32'd0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (imem_ack) begin
            if (ena) begin
              r_pc   <= w_next_pc;
              r_pend <= 1'b0;
            end else begin
              r_hold_buf <= imem_rdata;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (ena) begin
            r_pc    <= w_next_pc;
            r_pend  <= 1'b0;
            r_state <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
      // A redirect that cannot be applied now is remembered until the delay slot leaves.
      if (redirect && !w_deliver) begin
        r_pend        <= 1'b1;
        r_pend_target <= w_target_aligned;
      end
    end
  end

endmodule
